// File: rtl/seg_scan_2d.sv
// Two-digit 7-segment scan multiplexer: per-frame input capture, digit
// time-multiplexing onto one segment bus, and blanking dead-time at each switch.
module seg_scan_2d #(
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYC    = 16,
  parameter int COMMON_ANODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [6:0] seg_left,
  input  logic [6:0] seg_right,
  output logic [6:0] seg_out,
  output logic [1:0] dig_en,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic          INV       = (COMMON_ANODE != 0);

  typedef enum logic {
    SLOT_RIGHT = 1'b0,
    SLOT_LEFT  = 1'b1
  } slot_e;

  logic [CW-1:0] cnt_q, cnt_d;
  slot_e         slot_q, slot_d;
  logic [6:0]    shad_l_q, shad_l_d;
  logic [6:0]    shad_r_q, shad_r_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;
  logic          tick_q, tick_d;
  logic          cap;
  logic [6:0]    seg_raw;
  logic [1:0]    dig_raw;

  assign cap = ena && (cnt_q == '0) && (slot_q == SLOT_RIGHT);

  always_comb begin
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    shad_l_d = shad_l_q;
    shad_r_d = shad_r_q;
    tick_d   = cap;
    if (ena) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        slot_d = (slot_q == SLOT_RIGHT) ? SLOT_LEFT : SLOT_RIGHT;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (cap) begin
      shad_l_d = seg_left;
      shad_r_d = seg_right;
    end
  end

  // Output select uses pre-update state; capture cycle is always in dead-time.
  always_comb begin
    seg_raw = 7'h00;
    dig_raw = 2'b00;
    if (ena && (cnt_q >= BLANK_END)) begin
      if (slot_q == SLOT_RIGHT) begin
        seg_raw = shad_r_q;
        dig_raw = 2'b01;
      end else begin
        seg_raw = shad_l_q;
        dig_raw = 2'b10;
      end
    end
    seg_d = seg_raw ^ {7{INV}};
    dig_d = dig_raw ^ {2{INV}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      slot_q   <= SLOT_RIGHT;
      shad_l_q <= 7'h00;
      shad_r_q <= 7'h00;
      seg_q    <= {7{INV}};
      dig_q    <= {2{INV}};
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      shad_l_q <= shad_l_d;
      shad_r_q <= shad_r_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      tick_q   <= tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign dig_en     = dig_q;
  assign frame_tick = tick_q;

endmodule
